// File: rtl/mp3_bitstream_fetch_ctrl.sv
// MP3 bitstream fetch controller.
// Prefetches words from an upstream show-ahead FIFO into a small circular
// buffer and presents them to the Huffman decoder. Also flags frame sync
// words and counts the words that have been delivered.
//
// Handshake: a word moves to the decoder on every rising edge where
// word_valid and word_ready are both high. word_valid never depends on
// word_ready, and word_ready is ignored while word_valid is low.
// Upstream, fifo_ren is a pop strobe: the head word fifo_datain is taken
// on the same edge where fifo_ren is high.
module mp3_bitstream_fetch_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                         CLK_I,
    input  logic                         RST_I,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        fifo_datain,
    input  logic                         fifo_empty,
    output logic                         fifo_ren,
    output logic [DATA_WIDTH-1:0]        word_data,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         sync_hit,
    output logic [$clog2(DEPTH):0]       level,
    output logic [15:0]                  word_count,
    output logic [1:0]                   state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [LVL_W-1:0]        level_q;
    logic [LVL_W-1:0]        level_d;
    logic [15:0]             count_q;
    logic                    push;
    logic                    pop;

    // Push/pop strobes; a flush cancels both on its edge.
    always_comb begin
        push = (state_q == FETCH) && !fifo_empty && (level_q < DEPTH_L) && !flush;
        pop  = (level_q != '0) && word_ready && !flush;
    end

    // Occupancy after this edge, ignoring flush (flush overrides it below).
    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Next-state logic; flush wins over everything, including enable.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (enable) state_d = FETCH;
                FETCH: begin
                    if (!enable)                 state_d = IDLE;
                    else if (level_d == DEPTH_L) state_d = FULL;
                end
                FULL: begin
                    if (!enable)                state_d = IDLE;
                    else if (level_d < DEPTH_L) state_d = FETCH;
                end
                FLUSH:   state_d = enable ? FETCH : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Buffer storage; contents need no reset because level gates visibility.
    always_ff @(posedge CLK_I) begin
        if (push) mem[wr_ptr_q] <= fifo_datain;
    end

    // Control state: FSM, pointers, occupancy and delivered-word counter.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                level_q <= level_d;
                if (pop && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
            end
        end
    end

    // Outputs; the head word reads as zero whenever the buffer is empty.
    always_comb begin
        fifo_ren   = push;
        word_valid = (level_q != '0);
        word_data  = word_valid ? mem[rd_ptr_q] : '0;
        sync_hit   = word_valid && (word_data[15:4] == 12'hFFF);
        level      = level_q;
        word_count = count_q;
        state      = state_q;
    end

endmodule

// File: tb/tb_mp3_bitstream_fetch_ctrl.sv
// Directed bench for mp3_bitstream_fetch_ctrl with a queue-modelled
// upstream show-ahead FIFO.
module tb_mp3_bitstream_fetch_ctrl;

    logic        CLK_I;
    logic        RST_I;
    logic        enable;
    logic        flush;
    logic [15:0] fifo_datain;
    logic        fifo_empty;
    logic        fifo_ren;
    logic [15:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        sync_hit;
    logic [2:0]  level;
    logic [15:0] word_count;
    logic [1:0]  state;

    int checks;
    int errors;
    int ren_cnt;
    logic [15:0] up_q[$];
    logic [15:0] exp_head[7];
    logic        exp_sync[7];

    mp3_bitstream_fetch_ctrl #(.DATA_WIDTH(16), .DEPTH(4)) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .enable      (enable),
        .flush       (flush),
        .fifo_datain (fifo_datain),
        .fifo_empty  (fifo_empty),
        .fifo_ren    (fifo_ren),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .sync_hit    (sync_hit),
        .level       (level),
        .word_count  (word_count),
        .state       (state)
    );

    // Clock
    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the upstream head word.
    task automatic refresh();
        fifo_empty  = (up_q.size() == 0);
        fifo_datain = fifo_empty ? 16'h0000 : up_q[0];
    endtask

    // One clock: note the pop strobe, take the edge, then retire the
    // upstream word and return at posedge+1.
    task automatic tick();
        logic ren;
        #1;
        ren = fifo_ren;
        if (ren) ren_cnt++;
        @(posedge CLK_I);
        #1;
        if (ren && up_q.size() > 0) void'(up_q.pop_front());
        refresh();
    endtask

    initial begin
        checks = 0; errors = 0; ren_cnt = 0;
        RST_I = 1'b1; enable = 1'b0; flush = 1'b0; word_ready = 1'b0;
        refresh();
        exp_head = '{16'h0009, 16'h000A, 16'h000B, 16'h000C, 16'hFFEB, 16'hFFFB, 16'h0020};
        exp_sync = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset values
        #23;
        check("rst_state", state, 2'd0);
        check("rst_level", level, 3'd0);
        check("rst_valid", word_valid, 1'b0);
        check("rst_data", word_data, 16'h0000);
        check("rst_count", word_count, 16'd0);
        check("rst_ren", fifo_ren, 1'b0);
        RST_I = 1'b0;
        tick();

        // Fill: six upstream words, decoder stalled
        for (int i = 1; i <= 6; i++) up_q.push_back(16'(i));
        refresh();
        enable = 1'b1;
        ren_cnt = 0;
        repeat (8) tick();
        check("fill_ren_cycles", ren_cnt, 4);
        check("fill_level", level, 3'd4);
        check("fill_state", state, 2'd2);
        check("fill_data", word_data, 16'h0001);
        check("fill_upstream_left", up_q.size(), 2);

        // Streaming: eight words in order, upstream kept non-empty
        for (int i = 7; i <= 12; i++) up_q.push_back(16'(i));
        refresh();
        word_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("stream_data", word_data, 16'(i + 1));
            tick();
            check("stream_level", level, 3'd3);
        end
        check("stream_count", word_count, 16'd8);
        check("stream_head", word_data, 16'h0009);
        check("stream_state", state, 2'd1);
        word_ready = 1'b0;
        tick();
        check("refill_level", level, 3'd4);
        check("refill_state", state, 2'd2);

        // Sync detection
        up_q.push_back(16'hFFEB);
        up_q.push_back(16'hFFFB);
        up_q.push_back(16'h0020);
        refresh();
        word_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            check("sync_head", word_data, exp_head[i]);
            check("sync_hit", sync_hit, exp_sync[i]);
            tick();
        end
        check("drain_valid", word_valid, 1'b0);
        check("drain_sync", sync_hit, 1'b0);
        check("drain_count", word_count, 16'd15);

        // Underflow: decoder ready, nothing to deliver
        for (int i = 0; i < 10; i++) begin
            tick();
            check("uflow_valid", word_valid, 1'b0);
        end
        check("uflow_level", level, 3'd0);
        check("uflow_count", word_count, 16'd15);
        check("uflow_data", word_data, 16'h0000);

        // Flush with simultaneous push and pop
        word_ready = 1'b0;
        for (int i = 1; i <= 5; i++) up_q.push_back(16'h0100 + 16'(i));
        refresh();
        repeat (3) tick();
        check("preflush_level", level, 3'd3);
        flush = 1'b1;
        word_ready = 1'b1;
        #1;
        check("flush_ren", fifo_ren, 1'b0);
        tick();
        flush = 1'b0;
        word_ready = 1'b0;
        check("flush_level", level, 3'd0);
        check("flush_valid", word_valid, 1'b0);
        check("flush_state", state, 2'd3);
        check("flush_count", word_count, 16'd15);
        tick();
        check("postflush_state", state, 2'd1);
        check("postflush_level", level, 3'd0);
        tick();
        check("refetch_data", word_data, 16'h0104);
        tick();
        check("premrst_level", level, 3'd2);

        // Reset mid-operation
        up_q.push_back(16'h0201);
        refresh();
        #2;
        RST_I = 1'b1;
        #2;
        check("mrst_state", state, 2'd0);
        check("mrst_level", level, 3'd0);
        check("mrst_valid", word_valid, 1'b0);
        check("mrst_data", word_data, 16'h0000);
        check("mrst_count", word_count, 16'd0);
        check("mrst_sync", sync_hit, 1'b0);
        check("mrst_ren", fifo_ren, 1'b0);
        #10;
        RST_I = 1'b0;
        tick();
        check("resume_state", state, 2'd1);
        tick();
        check("resume_data", word_data, 16'h0201);
        check("resume_level", level, 3'd1);
        word_ready = 1'b1;
        tick();
        check("resume_count", word_count, 16'd1);
        check("resume_valid", word_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
